direct_mapped_cache: RTL and testbench
======================================

# direct_mapped_cache

Direct-mapped, write-through, no-write-allocate data cache between the processor's memory port (Address/WriteData/ReadData/MemRead/MemWrite/busy) and external memory (memAddress/memWriteData/memReadData/memMemWrite). It replaces the single-cycle read-stall shim in the processor top. Hits return data in the request cycle with no stall; misses stall the processor for exactly one cycle while the line is filled. The block also keeps saturating hit and miss counters for performance checks.

## Interface
- NBITS, 8, data width; word address is NBITS-2 bits, Address[NBITS-1:2].
- NLINES, 4, number of one-word lines (power of 2, 2..2^(NBITS-2)); IDX = $clog2(NLINES), TAG = NBITS-2-IDX.
- CW, 16, hit/miss counter width.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- Address  in  NBITS-2  word address from datapath; bits [IDX+1:2] index, [NBITS-1:IDX+2] tag.
- WriteData  in  NBITS  store data.
- MemRead  in  1  load request; held stable while busy=1.
- MemWrite  in  1  store request.
- flush  in  1  synchronous invalidate-all.
- ReadData  out  NBITS  load data to datapath.
- busy  out  1  stall to controller.
- memAddress  out  NBITS-2  to memory.
- memWriteData  out  NBITS  to memory.
- memMemWrite  out  1  memory write strobe.
- memReadData  in  NBITS  memory data; valid the cycle after memAddress is presented (registered read, 1-cycle latency).
- hit_count, miss_count  out  CW  saturating load hit/miss counters.

## Operation
- Storage: per line valid bit, TAG-bit tag, NBITS data. hit = valid[idx] & (tag[idx]==Address tag).
- FSM states IDLE and FILL.
  - IDLE: MemRead & ~MemWrite & hit → ReadData = line data, busy=0, hit_count+1. MemRead & ~MemWrite & miss → busy=1, go to FILL, miss_count+1.
  - FILL: busy=0, ReadData = memReadData, and at the clock edge the line is written (valid=1, tag, data). Always returns to IDLE.
- Stores are write-through. memMemWrite = MemWrite in IDLE and never stalls. On a hit the line data is updated with WriteData; on a miss the cache is unchanged (no allocate).
- MemRead and MemWrite both high: treated as a store only. busy=0, ReadData = 0, counters unchanged.
- MemWrite in FILL: ignored (memMemWrite=0); the controller does not issue it while stalled.
- memAddress = Address and memWriteData = WriteData are always passthrough.
- flush=1 at an edge clears all valid bits. flush in FILL suppresses the line write, but the data is still returned and busy still drops as scheduled. flush does not affect the counters.
- Counters stick at 2^CW-1.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, all valid=0, hit_count=miss_count=0. busy=0, memMemWrite=0 and ReadData=0 while reset is low.
- Load hit: 0 stall cycles; data is valid combinationally in the request cycle.
- Load miss: cycle C has busy=1 and memAddress=Address. Cycle C+1 has busy=0 and ReadData=memReadData. The line is valid from C+2.
- A load to the same address at C+2 hits.
- Store: memMemWrite is asserted in the same cycle, with no stall.
- Reset mid-FILL: the fill is abandoned, no line is written, and busy=0 immediately.

## Test plan
- NBITS=8, NLINES=4, after reset: load 6'h05 (miss). Required:
  - cycle 0: busy=1, memAddress=6'h05, miss_count=0→1.
  - cycle 1: memReadData=8'hA5 → ReadData=8'hA5, busy=0.
- Load 6'h05 again with memReadData=8'h00 → busy=0, ReadData=8'hA5 in the same cycle, hit_count=1.
- Conflict: load 6'h09 (same index 1), fill 8'h3C → miss_count=2. Then load 6'h05 → miss again (miss_count=3).
- Store 6'h09 with 8'h77 after it is cached → memMemWrite=1, memWriteData=8'h77, busy=0. A later load of 6'h09 hits with 8'h77.
- Store miss to 6'h02 with 8'h11 → memMemWrite=1, no allocate. A later load of 6'h02 shows busy=1 (miss).
- Flush after lines are valid → a load of 6'h09 misses. Assert reset=0 during that FILL → busy=0 immediately. After release, both counters read 0 and a load of 6'h05 misses.

Source files
------------

// File: rtl/direct_mapped_cache_if.sv
// ---------------------------------------------------------------------------
// direct_mapped_cache_if
//   Processor-side memory port of the data cache.
//   master : datapath/controller (drives the request, receives data + stall)
//   slave  : the cache
//   Address   word address (byte address bits [NBITS-1:2])
//   WriteData store data
//   MemRead   load request, held stable while busy=1
//   MemWrite  store request
//   ReadData  load data back to the datapath
//   busy      stall to the controller
// ---------------------------------------------------------------------------
interface direct_mapped_cache_if #(
  parameter int NBITS = 8
);
  logic [NBITS-3:0] Address;
  logic [NBITS-1:0] WriteData;
  logic             MemRead;
  logic             MemWrite;
  logic [NBITS-1:0] ReadData;
  logic             busy;

  modport master (
    output Address, WriteData, MemRead, MemWrite,
    input  ReadData, busy
  );

  modport slave (
    input  Address, WriteData, MemRead, MemWrite,
    output ReadData, busy
  );
endinterface

// File: rtl/direct_mapped_cache.sv
// ---------------------------------------------------------------------------
// direct_mapped_cache
//   Direct-mapped, write-through, no-write-allocate data cache with one-word
//   lines. Load hits return data combinationally with no stall; a load miss
//   stalls for one cycle (FILL) while memory returns the word. Stores are
//   passed straight to memory and update the line only when it already holds
//   that address. Saturating load hit/miss counters are provided.
//
//   clock        rising-edge clock
//   reset        asynchronous, active-low
//   flush        synchronous invalidate-all
//   cpu          processor port (direct_mapped_cache_if.slave)
//   memAddress   word address to memory (passthrough of cpu.Address)
//   memWriteData store data to memory (passthrough of cpu.WriteData)
//   memMemWrite  memory write strobe
//   memReadData  memory read data, valid one cycle after memAddress
//   hit_count    saturating load-hit counter
//   miss_count   saturating load-miss counter
// ---------------------------------------------------------------------------
module direct_mapped_cache #(
  parameter int NBITS  = 8,
  parameter int NLINES = 4,
  parameter int CW     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  direct_mapped_cache_if.slave cpu,
  output logic [NBITS-3:0]     memAddress,
  output logic [NBITS-1:0]     memWriteData,
  output logic                 memMemWrite,
  input  logic [NBITS-1:0]     memReadData,
  output logic [CW-1:0]        hit_count,
  output logic [CW-1:0]        miss_count
);

  localparam int IDX   = $clog2(NLINES);
  localparam int TAG   = NBITS - 2 - IDX;
  // A fully-indexed configuration has no tag bits; keep a 1-bit constant-zero
  // tag so the compare below still works and always matches.
  localparam int TAG_W = (TAG > 0) ? TAG : 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Line storage
  logic [NLINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [NBITS-1:0]  data_q [NLINES];

  // Line being filled, captured in the miss cycle
  logic [IDX-1:0]    fill_idx;
  logic [TAG_W-1:0]  fill_tag;

  // Request decode
  logic [IDX-1:0]    req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              rd_req;
  logic              load_hit;
  logic              load_miss;
  logic              store_hit;
  logic              fill_we;

  logic              busy_o;
  logic [NBITS-1:0]  read_data_o;

  assign req_idx = cpu.Address[IDX-1:0];
  assign req_tag = TAG_W'(cpu.Address >> IDX);
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // A simultaneous load and store is handled as a store only.
  assign rd_req    = cpu.MemRead && !cpu.MemWrite;
  assign load_hit  = (state_q == IDLE) && rd_req && hit;
  assign load_miss = (state_q == IDLE) && rd_req && !hit;
  assign store_hit = (state_q == IDLE) && cpu.MemWrite && hit;
  // A flush landing on the fill edge wins: the word is still returned to the
  // datapath but the line is not allocated.
  assign fill_we   = (state_q == FILL) && !flush;

  assign memAddress   = cpu.Address;
  assign memWriteData = cpu.WriteData;
  assign cpu.busy     = busy_o;
  assign cpu.ReadData = read_data_o;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rd_req && !hit) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  // Outputs are also forced quiet while reset is held, so a request presented
  // during reset neither stalls the controller nor strobes memory.
  always_comb begin
    busy_o      = 1'b0;
    read_data_o = '0;
    memMemWrite = 1'b0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          busy_o      = rd_req && !hit;
          memMemWrite = cpu.MemWrite;
          if (rd_req && hit) read_data_o = data_q[req_idx];
        end
        FILL: read_data_o = memReadData;
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Valid bits, fill bookkeeping and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      fill_idx   <= '0;
      fill_tag   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (flush)        valid_q           <= '0;
      else if (fill_we) valid_q[fill_idx] <= 1'b1;

      if (load_miss) begin
        fill_idx <= req_idx;
        fill_tag <= req_tag;
      end

      if (load_hit && (hit_count != '1))   hit_count  <= hit_count + 1'b1;
      if (load_miss && (miss_count != '1)) miss_count <= miss_count + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Tag and data arrays
  // -------------------------------------------------------------------------
  // NOTE: the arrays carry no reset; valid_q alone decides whether a line's
  // contents mean anything, so clearing them would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= memReadData;
    end else if (store_hit) begin
      data_q[req_idx] <= cpu.WriteData;
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// ---------------------------------------------------------------------------
// tb_direct_mapped_cache
//   Directed scenario followed by a randomized run. The reference model keeps
//   a flat word memory plus, per line slot, which word address is resident.
//   Because the cache is write-through, every load must return the memory
//   model's current word, hit or miss. Counters use a small width so the
//   saturation limit is reached during the random run.
// ---------------------------------------------------------------------------
module tb_direct_mapped_cache;

  localparam int NBITS  = 8;
  localparam int NLINES = 4;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic [NBITS-3:0]  memAddress;
  logic [NBITS-1:0]  memWriteData;
  logic              memMemWrite;
  logic [NBITS-1:0]  memReadData;
  logic [CW-1:0]     hit_count;
  logic [CW-1:0]     miss_count;

  always #5 clock = ~clock;

  direct_mapped_cache_if #(.NBITS(NBITS)) bus ();

  direct_mapped_cache #(
    .NBITS  (NBITS),
    .NLINES (NLINES),
    .CW     (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .cpu          (bus),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memMemWrite  (memMemWrite),
    .memReadData  (memReadData),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [NBITS-1:0] mem [64];
  bit               mvalid [NLINES];
  logic [5:0]       mline  [NLINES];
  int               mhc, mmc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then applied.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle well before the next rising edge.
  task automatic settle();
    #3;
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [5:0] a,
                        input logic [7:0] wd, input logic [7:0] mrd, input logic fl);
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.Address   = a;
    bus.WriteData = wd;
    memReadData   = mrd;
    flush         = fl;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NLINES; i++) mvalid[i] = 1'b0;
  endtask

  task automatic check_counts(input string where);
    check({where, "_hit_count"},  32'(hit_count),  32'(mhc));
    check({where, "_miss_count"}, 32'(miss_count), 32'(mmc));
  endtask

  initial begin
    logic [5:0] a;
    logic [7:0] wd;
    int         op, idx;
    bit         fl, fl2, mhit;

    // ------------------------------------------------------------ reset
    reset = 1'b0;
    set_in(1'b1, 1'b0, 6'h05, 8'h00, 8'h5A, 1'b0);
    settle();
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_readdata", 32'(bus.ReadData), 32'd0);
    check("rst_hit",      32'(hit_count),    32'd0);
    check("rst_miss",     32'(miss_count),   32'd0);
    bus.MemWrite = 1'b1;
    #1;
    check("rst_memwrite", 32'(memMemWrite),  32'd0);
    cyc();
    reset = 1'b1;
    set_in(1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0);

    // ------------------------------------------------------------ first miss
    cyc();
    set_in(1'b1, 1'b0, 6'h05, 8'h00, 8'h00, 1'b0);
    settle();
    check("miss05_busy",    32'(bus.busy),   32'd1);
    check("miss05_memaddr", 32'(memAddress), 32'h05);
    check("miss05_cnt0",    32'(miss_count), 32'd0);
    cyc();
    memReadData = 8'hA5;
    settle();
    check("fill05_busy", 32'(bus.busy),     32'd0);
    check("fill05_data", 32'(bus.ReadData), 32'hA5);
    check("fill05_cnt1", 32'(miss_count),   32'd1);

    // ------------------------------------------------------------ hit
    cyc();
    set_in(1'b1, 1'b0, 6'h05, 8'h00, 8'h00, 1'b0);
    settle();
    check("hit05_busy", 32'(bus.busy),     32'd0);
    check("hit05_data", 32'(bus.ReadData), 32'hA5);

    // ------------------------------------------------------------ conflict
    cyc();
    set_in(1'b1, 1'b0, 6'h09, 8'h00, 8'h00, 1'b0);
    settle();
    check("hit05_cnt",   32'(hit_count), 32'd1);
    check("miss09_busy", 32'(bus.busy),  32'd1);
    cyc();
    memReadData = 8'h3C;
    settle();
    check("fill09_data", 32'(bus.ReadData), 32'h3C);
    check("fill09_cnt",  32'(miss_count),   32'd2);
    cyc();
    set_in(1'b1, 1'b0, 6'h05, 8'h00, 8'h00, 1'b0);
    settle();
    check("evict05_busy", 32'(bus.busy), 32'd1);
    cyc();
    memReadData = 8'hA5;
    settle();
    check("evict05_cnt", 32'(miss_count), 32'd3);

    // ------------------------------------------------------------ store hit
    cyc();
    set_in(1'b1, 1'b0, 6'h09, 8'h00, 8'h00, 1'b0);
    cyc();
    memReadData = 8'h3C;
    cyc();
    set_in(1'b0, 1'b1, 6'h09, 8'h77, 8'h00, 1'b0);
    settle();
    check("st09_memwrite", 32'(memMemWrite),  32'd1);
    check("st09_wdata",    32'(memWriteData), 32'h77);
    check("st09_busy",     32'(bus.busy),     32'd0);
    cyc();
    set_in(1'b1, 1'b0, 6'h09, 8'h00, 8'h00, 1'b0);
    settle();
    check("ld09_busy", 32'(bus.busy),     32'd0);
    check("ld09_data", 32'(bus.ReadData), 32'h77);

    // ------------------------------------------------------------ store miss
    cyc();
    set_in(1'b0, 1'b1, 6'h02, 8'h11, 8'h00, 1'b0);
    settle();
    check("st02_memwrite", 32'(memMemWrite), 32'd1);
    check("st02_busy",     32'(bus.busy),    32'd0);
    check("st02_hitcnt",   32'(hit_count),   32'd2);
    cyc();
    set_in(1'b1, 1'b0, 6'h02, 8'h00, 8'h00, 1'b0);
    settle();
    check("ld02_noalloc", 32'(bus.busy), 32'd1);
    cyc();
    memReadData = 8'h11;
    settle();
    check("ld02_fill", 32'(bus.ReadData), 32'h11);

    // ------------------------------------------------------------ flush + reset mid-fill
    cyc();
    set_in(1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b1);
    cyc();
    set_in(1'b1, 1'b0, 6'h09, 8'h00, 8'h00, 1'b0);
    settle();
    check("flush09_busy", 32'(bus.busy), 32'd1);
    cyc();
    memReadData = 8'h3C;
    reset = 1'b0;
    #1;
    check("rstfill_busy", 32'(bus.busy),     32'd0);
    check("rstfill_data", 32'(bus.ReadData), 32'd0);
    cyc();
    reset = 1'b1;
    set_in(1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0);
    settle();
    check("postrst_hit",  32'(hit_count),  32'd0);
    check("postrst_miss", 32'(miss_count), 32'd0);
    cyc();
    set_in(1'b1, 1'b0, 6'h05, 8'h00, 8'h00, 1'b0);
    settle();
    check("postrst05_busy", 32'(bus.busy), 32'd1);
    cyc();
    memReadData = 8'hA5;
    settle();
    check("postrst05_data", 32'(bus.ReadData), 32'hA5);

    // ------------------------------------------------------------ random run
    cyc();
    reset = 1'b0;
    set_in(1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    model_clear();
    mhc = 0;
    mmc = 0;

    for (int n = 0; n < 500; n++) begin
      op  = int'($urandom_range(0, 9));
      a   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 11));
      wd  = 8'($urandom);
      fl  = (op == 8) || ($urandom_range(0, 15) == 0);
      idx = int'(a) % NLINES;
      mhit = mvalid[idx] && (mline[idx] == a);

      cyc();
      set_in(op <= 4 || op == 7, op == 5 || op == 6 || op == 7, a, wd, 8'($urandom), fl);
      settle();
      check_counts("rnd");
      check("rnd_memaddr", 32'(memAddress), 32'(a));

      if (op <= 4) begin
        check("rnd_ld_busy", 32'(bus.busy), 32'(!mhit));
        check("rnd_ld_wr",   32'(memMemWrite), 32'd0);
        if (mhit) begin
          check("rnd_hit_data", 32'(bus.ReadData), 32'(mem[a]));
          if (mhc < CMAX) mhc++;
          if (fl) model_clear();
        end else begin
          if (mmc < CMAX) mmc++;
          if (fl) model_clear();
          fl2 = ($urandom_range(0, 7) == 0);
          cyc();
          memReadData = mem[a];
          flush       = fl2;
          settle();
          check_counts("rnd_fill");
          check("rnd_fill_busy", 32'(bus.busy),     32'd0);
          check("rnd_fill_data", 32'(bus.ReadData), 32'(mem[a]));
          check("rnd_fill_wr",   32'(memMemWrite),  32'd0);
          if (fl2) model_clear();
          else begin
            mvalid[idx] = 1'b1;
            mline[idx]  = a;
          end
        end
      end else if (op <= 7) begin
        check("rnd_st_wr",    32'(memMemWrite),  32'd1);
        check("rnd_st_wdata", 32'(memWriteData), 32'(wd));
        check("rnd_st_busy",  32'(bus.busy),     32'd0);
        if (op == 7) check("rnd_both_data", 32'(bus.ReadData), 32'd0);
        mem[a] = wd;
        if (fl) model_clear();
      end else begin
        check("rnd_idle_busy", 32'(bus.busy),    32'd0);
        check("rnd_idle_wr",   32'(memMemWrite), 32'd0);
        if (fl) model_clear();
      end
    end

    cyc();
    set_in(1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0);
    settle();
    check_counts("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
